// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c bus arbiter slice.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;
endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Client request/response bundle plus the single i2c_master handshake.
interface i2c_bus_arbiter_if #(parameter int NUM_REQ = 4);
   // client side
   logic [NUM_REQ-1:0]                          req;
   logic [NUM_REQ-1:0][i2c_pkg::I2C_ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]                          req_rw;
   logic [NUM_REQ-1:0][i2c_pkg::I2C_DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]                          grant;
   logic [NUM_REQ-1:0]                          done;
   logic [i2c_pkg::I2C_DATA_W-1:0]              rdata;
   logic                                        err;
   // master side
   logic                                        m_start;
   logic [i2c_pkg::I2C_ADDR_W-1:0]              m_addr;
   logic                                        m_rw;
   logic [i2c_pkg::I2C_DATA_W-1:0]              m_wdata;
   logic [i2c_pkg::I2C_DATA_W-1:0]              m_rdata;
   logic                                        m_busy;

   modport slave (
      input  req, req_addr, req_rw, req_wdata, m_rdata, m_busy,
      output grant, done, rdata, err, m_start, m_addr, m_rw, m_wdata
   );

   modport master (
      output req, req_addr, req_rw, req_wdata, m_rdata, m_busy,
      input  grant, done, rdata, err, m_start, m_addr, m_rw, m_wdata
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req scanning upward from ptr with wrap.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);
   logic [IDX_W-1:0] cand;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   always_comb begin
      gnt  = '0;
      idx  = '0;
      vld  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = wrap_add(ptr, k);
         if (!vld && req[cand]) begin
            vld       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one i2c_master among NUM_REQ clients.
// Optional launch/run watchdog: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter int          NUM_REQ    = 4,
   parameter logic [15:0] LAUNCH_MAX = 16'd4000
) (
   input logic               clk,
   input logic               reset,
   i2c_bus_arbiter_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state, state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] win_gnt;
   logic [IDX_W-1:0]   win_idx;
   logic               win_vld;
   logic               tmo;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req (bus.req),
      .ptr (ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .vld (win_vld)
   );

`ifdef I2C_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (reset || state_nxt != state) tmo_cnt <= '0;
      else if (state == ST_LAUNCH || state == ST_RUN) tmo_cnt <= tmo_cnt + 16'd1;
   end

   assign tmo = (state == ST_LAUNCH || state == ST_RUN) && (tmo_cnt == LAUNCH_MAX - 16'd1);
`else
   logic unused_launch_max;
   assign unused_launch_max = ^LAUNCH_MAX;
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (|bus.req) state_nxt = ST_ARB;
         // req may have dropped between IDLE and ARB; fall back quietly
         ST_ARB:    state_nxt = win_vld ? ST_LAUNCH : ST_IDLE;
         ST_LAUNCH: if (tmo) state_nxt = ST_DONE;
                    else if (bus.m_start && bus.m_busy) state_nxt = ST_RUN;
         ST_RUN:    if (tmo || !bus.m_busy) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.grant   <= '0;
         bus.done    <= '0;
         bus.rdata   <= '0;
         bus.err     <= 1'b0;
         bus.m_start <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_rw    <= RW_WRITE;
         bus.m_wdata <= '0;
         ptr         <= '0;
      end else begin
         bus.done <= '0;
         bus.err  <= 1'b0;
         unique case (state)
            ST_ARB: if (win_vld) begin
               bus.grant   <= win_gnt;
               bus.m_addr  <= bus.req_addr[win_idx];
               bus.m_rw    <= bus.req_rw[win_idx];
               bus.m_wdata <= bus.req_wdata[win_idx];
               ptr         <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
               // a busy master is still finishing someone else's job: hold start off
               bus.m_start <= !bus.m_busy;
            end
            ST_LAUNCH: begin
               if (tmo) begin
                  bus.m_start <= 1'b0;
                  bus.done    <= bus.grant;
                  bus.err     <= 1'b1;
                  bus.rdata   <= 8'hFF;
               end else if (!bus.m_start && !bus.m_busy) begin
                  bus.m_start <= 1'b1;
               end else if (bus.m_start && bus.m_busy) begin
                  bus.m_start <= 1'b0;
               end
            end
            ST_RUN: begin
               if (tmo) begin
                  bus.done  <= bus.grant;
                  bus.err   <= 1'b1;
                  bus.rdata <= 8'hFF;
               end else if (!bus.m_busy) begin
                  bus.done <= bus.grant;
                  if (bus.m_rw == RW_READ) bus.rdata <= bus.m_rdata;
               end
            end
            ST_DONE: bus.grant <= '0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter with a behavioural i2c_master and round-robin model.
module tb_i2c_bus_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_REQ(N)) bus();

  i2c_bus_arbiter #(.NUM_REQ(N), .LAUNCH_MAX(16'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

  // ---------------- behavioural i2c_master ----------------
  int force_busy = 0;
  bit forcing = 1'b0;
  bit mute = 1'b0;
  int next_len = -1;
  int ovr_rdata = -1;
  int job_len;
  logic [7:0] last_rdata = '0;
  logic [6:0] cap_addr;
  logic       cap_rw;
  logic [7:0] cap_wdata;

  initial begin
    bus.m_busy = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_busy > 0) begin
        bus.m_busy = 1'b1; forcing = 1'b1;
        force_busy--;
        if (force_busy == 0) begin bus.m_busy = 1'b0; forcing = 1'b0; end
      end else if (!mute && bus.m_start && !bus.m_busy) begin
        cap_addr = bus.m_addr; cap_rw = bus.m_rw; cap_wdata = bus.m_wdata;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        last_rdata = (ovr_rdata >= 0) ? 8'(ovr_rdata) : 8'($urandom);
        ovr_rdata = -1;
        bus.m_rdata = last_rdata;
        bus.m_busy = 1'b1;
        job_len = (next_len > 0) ? next_len : int'($urandom_range(3, 20));
        next_len = -1;
        repeat (job_len) @(negedge clk);
        bus.m_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [N-1:0] req_v = '0;
  logic [6:0] cli_addr [N];
  logic       cli_rw   [N];
  logic [7:0] cli_wd   [N];
  int ptr_m = 0;
  logic [7:0] exp_rdata = '0;

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0; r[w] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_cli(input int c, input logic [6:0] a, input logic rw, input logic [7:0] d);
    cli_addr[c] = a; cli_rw[c] = rw; cli_wd[c] = d;
    bus.req_addr[c] = a; bus.req_rw[c] = rw; bus.req_wdata[c] = d;
  endtask

  task automatic raise(input int c);
    req_v[c] = 1'b1;
    bus.req = req_v;
  endtask

  task automatic raise_random();
    int c;
    c = int'($urandom_range(0, N-1));
    if (!req_v[c]) begin
      set_cli(c, 7'($urandom), 1'($urandom), 8'($urandom));
      raise(c);
    end
  endtask

  task automatic do_txn(input bit chk_lat);
    int w;
    bit got, bad_g, forced_start, first;
    w = rr_pick(req_v, ptr_m);
    got = 1'b0; bad_g = 1'b0; forced_start = 1'b0; first = 1'b1;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      tick();
      if (forcing && bus.m_start) forced_start = 1'b1;
      if (bus.grant != '0 && bus.grant != onehot(w)) bad_g = 1'b1;
      if (chk_lat && first && bus.grant != '0) begin
        chk("start_lat", bus.m_start, 1);
        first = 1'b0;
      end
      if (bus.done != '0) got = 1'b1;
      else if (bus.grant != '0 && $urandom_range(0, 15) == 0) raise_random();
    end
    chk("done_seen", got, 1);
    chk("done", bus.done, onehot(w));
    chk("grant", bus.grant, onehot(w));
    chk("grant_stable", bad_g, 0);
    chk("start_in_busy", forced_start, 0);
    chk("cap_addr", cap_addr, cli_addr[w]);
    chk("cap_rw", cap_rw, cli_rw[w]);
    chk("cap_wdata", cap_wdata, cli_wd[w]);
    if (cli_rw[w]) exp_rdata = last_rdata;
    chk("rdata", bus.rdata, exp_rdata);
    chk("err", bus.err, 0);
    req_v[w] = 1'b0;
    bus.req = req_v;
    ptr_m = (w + 1) % N;
    tick();
    chk("done_pulse", bus.done, 0);
    chk("grant_clr", bus.grant, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_m = 0;
    exp_rdata = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int k_done;
    bus.req = '0;
    for (int c = 0; c < N; c++) set_cli(c, '0, 1'b0, '0);
    repeat (3) tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start", bus.m_start, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_maddr", {bus.m_addr, bus.m_rw, bus.m_wdata}, 0);
    reset = 1'b0;
    tick();

    // single write
    set_cli(0, 7'h48, 1'b0, 8'hA5);
    next_len = 50;
    raise(0);
    do_txn(1);

    // single read
    set_cli(2, 7'h68, 1'b1, 8'h00);
    ovr_rdata = 8'h3C;
    raise(2);
    do_txn(1);
    chk("rdata_3c", bus.rdata, 8'h3C);

    // contention from ptr=0, then wrap
    do_reset();
    for (int c = 0; c < N; c++) begin
      set_cli(c, 7'(8'h10 + c), 1'(c % 2), 8'(c * 17));
      raise(c);
    end
    for (int t = 0; t < N; t++) do_txn(0);
    for (int c = 0; c < N; c++) raise(c);
    chk("wrap_pick", rr_pick(req_v, ptr_m), 0);
    for (int t = 0; t < N; t++) do_txn(0);

    // master already busy when the transaction launches
    force_busy = 20;
    tick();
    set_cli(1, 7'h22, 1'b0, 8'h5A);
    raise(1);
    do_txn(0);

    // reset in RUN
    set_cli(0, 7'h33, 1'b1, 8'h00);
    next_len = 40;
    raise(0);
    seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      tick();
      seen = bus.m_busy && (bus.grant != '0);
    end
    chk("run_reached", seen, 1);
    repeat (10) tick();
    req_v = '0; bus.req = '0;
    do_reset();
    chk("rrst_grant", bus.grant, 0);
    chk("rrst_start", bus.m_start, 0);
    chk("rrst_done", bus.done, 0);
    set_cli(2, 7'h44, 1'b1, 8'h00);
    raise(2);
    do_txn(0);

    // master never answers
    mute = 1'b1;
    set_cli(3, 7'h55, 1'b1, 8'h00);
    raise(3);
    seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      tick();
      seen = (bus.grant != '0);
    end
    chk("mute_grant", bus.grant, onehot(3));
    k_done = -1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (bus.done != '0 && k_done < 0) begin
        k_done = k;
`ifdef I2C_ARB_TIMEOUT_EN
        chk("tmo_done", bus.done, onehot(3));
        chk("tmo_err", bus.err, 1);
        chk("tmo_rdata", bus.rdata, 8'hFF);
`endif
      end
    end
`ifdef I2C_ARB_TIMEOUT_EN
    chk("tmo_cycle", k_done, 100);
    chk("tmo_start", bus.m_start, 0);
    req_v = '0; bus.req = '0;
    ptr_m = 0;
    exp_rdata = 8'hFF;
    tick();
`else
    chk("stuck_done", k_done, -1);
    chk("stuck_start", bus.m_start, 1);
    chk("stuck_grant", bus.grant, onehot(3));
    req_v = '0; bus.req = '0;
    do_reset();
`endif
    mute = 1'b0;
    repeat (3) tick();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < N; c++)
        if (!req_v[c] && $urandom_range(0, 1) == 1) begin
          set_cli(c, 7'($urandom), 1'($urandom), 8'($urandom));
          raise(c);
        end
      if (req_v == '0) raise_random();
      if (req_v == '0) begin
        set_cli(0, 7'($urandom), 1'($urandom), 8'($urandom));
        raise(0);
      end
      do_txn(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
